flash_stream_reader: RTL

Parametrised successor to the fixed-size flash byte reader. It streams a programmable byte range out of 8-bit parallel flash and packs the bytes into little-endian words of BYTES_PER_WORD bytes. It adds programmable access wait states, a start/done handshake, downstream backpressure, partial final words and optional looping. It sits between the board flash pins and the frame-buffer/SDRAM write path of the photo demos.

---
 rtl/flash_stream_reader_pkg.sv | 20 ++
 rtl/flash_stream_reader_byte_packer.sv | 54 +++++
 rtl/flash_stream_reader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/flash_stream_reader_pkg.sv
// Shared definitions for the flash stream reader: controller state encoding
// and wait-state counter sizing.
package flash_stream_reader_pkg;

  // Wait counter must hold the largest supported WAIT_CYCLES value (15).
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_PUSH   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Reload value for the per-byte wait counter.
  function automatic logic [WAIT_W-1:0] wait_reload(input int cycles);
    return WAIT_W'(cycles);
  endfunction

endpackage

// File: rtl/flash_stream_reader_byte_packer.sv
// Packs flash bytes little-endian into an output word. A clear starts a new
// word (all lanes zero, lane index 0); each strobe writes one byte lane.
module flash_byte_packer
  import flash_stream_reader_pkg::*;
#(
  parameter int BYTES_PER_WORD = 3,
  parameter int WORD_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              strobe,
  input  logic [7:0]        data_byte,
  output logic [WORD_W-1:0] word,
  output logic              last_lane
);

  logic [1:0]        idx_r;
  logic [WORD_W-1:0] word_r;

  // Lane index: restarts on clear, advances once per captured byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= 2'd0;
    end else if (clear) begin
      idx_r <= 2'd0;
    end else if (strobe) begin
      idx_r <= idx_r + 2'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Word register: cleared per word so lanes of a partial word read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= {WORD_W{1'b0}};
    end else if (clear) begin
      word_r <= {WORD_W{1'b0}};
    end else if (strobe) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (idx_r == 2'(i)) begin
          word_r[8*i +: 8] <= data_byte;
        end
      end
    end else begin
      word_r <= word_r;
    end
  end

  assign word      = word_r;
  assign last_lane = (idx_r == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/flash_stream_reader.sv
// Streams a programmable byte range from 8-bit parallel flash and emits
// little-endian packed words with valid/ready backpressure and optional looping.
module flash_stream_reader
  import flash_stream_reader_pkg::*;
#(
  parameter int ADDR_W         = 22,
  parameter int BYTES_PER_WORD = 3,
  parameter int WORD_W         = 32,
  parameter int WAIT_CYCLES    = 0
) (
  input  logic              iCLK,
  input  logic              iRSTN,
  input  logic              iSTART,
  input  logic [ADDR_W-1:0] iBASE_ADDR,
  input  logic [ADDR_W-1:0] iLENGTH,
  input  logic              iLOOP,
  input  logic              iRY,
  input  logic [7:0]        iDATA,
  output logic              oCE_N,
  output logic              oOE_N,
  output logic [ADDR_W-1:0] oADDR,
  output logic [WORD_W-1:0] oDATA,
  output logic              oDVALID,
  input  logic              iDREADY,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam logic [WAIT_W-1:0] WAIT_RELOAD = wait_reload(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_ZERO   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] base_r, base_n_s, len_r, len_n_s;
  logic [ADDR_W-1:0] remaining_r, remaining_n_s, addr_r, addr_n_s;
  logic [WAIT_W-1:0] wait_r, wait_n_s;
  logic              dvalid_r, dvalid_n_s, done_r, done_n_s;
  logic              busy_r, busy_n_s, ce_n_r, ce_n_n_s;
  logic              clear_s, strobe_s, last_lane_s;
  logic              byte_fire_s, accept_s, last_byte_s, more_s;
  logic [WORD_W-1:0] word_s;

  assign byte_fire_s = (state_r == ST_ACCESS) && iRY && (wait_r == {WAIT_W{1'b0}});
  assign accept_s    = (state_r == ST_PUSH) && iDREADY;
  assign last_byte_s = (remaining_r == ADDR_ONE);
  assign more_s      = (remaining_r != ADDR_ZERO);

  flash_byte_packer #(
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .WORD_W         (WORD_W)
  ) u_packer (
    .clk       (iCLK),
    .rst_n     (iRSTN),
    .clear     (clear_s),
    .strobe    (strobe_s),
    .data_byte (iDATA),
    .word      (word_s),
    .last_lane (last_lane_s)
  );

  // State register.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (iSTART) begin
          if (iLENGTH == ADDR_ZERO) state_next_s = ST_DONE;
          else                      state_next_s = ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (byte_fire_s && (last_lane_s || last_byte_s)) state_next_s = ST_PUSH;
        else                                             state_next_s = ST_ACCESS;
      end
      ST_PUSH: begin
        if (accept_s) begin
          if (more_s || iLOOP) state_next_s = ST_ACCESS;
          else                 state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_PUSH;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Next values for counters, strobes and registered outputs.
  always_comb begin
    base_n_s      = base_r;
    len_n_s       = len_r;
    remaining_n_s = remaining_r;
    addr_n_s      = addr_r;
    wait_n_s      = wait_r;
    dvalid_n_s    = dvalid_r;
    done_n_s      = 1'b0;
    clear_s       = 1'b0;
    strobe_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (iSTART) begin
          base_n_s      = iBASE_ADDR;
          len_n_s       = iLENGTH;
          remaining_n_s = iLENGTH;
          clear_s       = 1'b1;
          if (iLENGTH != ADDR_ZERO) begin
            addr_n_s = iBASE_ADDR;
            wait_n_s = WAIT_RELOAD;
          end else begin
            done_n_s = 1'b1;
          end
        end else begin
          dvalid_n_s = 1'b0;
        end
      end
      ST_ACCESS: begin
        // A low iRY freezes the wait counter, address and packer.
        if (iRY) begin
          if (wait_r != {WAIT_W{1'b0}}) begin
            wait_n_s = wait_r - 4'd1;
          end else begin
            strobe_s      = 1'b1;
            remaining_n_s = remaining_r - ADDR_ONE;
            if (last_lane_s || last_byte_s) begin
              dvalid_n_s = 1'b1;
            end else begin
              addr_n_s = addr_r + ADDR_ONE;
              wait_n_s = WAIT_RELOAD;
            end
          end
        end else begin
          wait_n_s = wait_r;
        end
      end
      ST_PUSH: begin
        if (accept_s) begin
          dvalid_n_s = 1'b0;
          clear_s    = 1'b1;
          wait_n_s   = WAIT_RELOAD;
          if (more_s) begin
            addr_n_s = addr_r + ADDR_ONE;
          end else if (iLOOP) begin
            addr_n_s      = base_r;
            remaining_n_s = len_r;
            done_n_s      = 1'b1;
          end else begin
            done_n_s = 1'b1;
          end
        end else begin
          dvalid_n_s = 1'b1;
        end
      end
      ST_DONE: begin
        done_n_s = 1'b0;
      end
      default: begin
        dvalid_n_s = 1'b0;
      end
    endcase
    busy_n_s = (state_next_s != ST_IDLE);
    ce_n_n_s = (state_next_s != ST_ACCESS);
  end

  // Datapath and output registers.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      base_r      <= ADDR_ZERO;
      len_r       <= ADDR_ZERO;
      remaining_r <= ADDR_ZERO;
      addr_r      <= ADDR_ZERO;
      wait_r      <= {WAIT_W{1'b0}};
      dvalid_r    <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      ce_n_r      <= 1'b1;
    end else begin
      base_r      <= base_n_s;
      len_r       <= len_n_s;
      remaining_r <= remaining_n_s;
      addr_r      <= addr_n_s;
      wait_r      <= wait_n_s;
      dvalid_r    <= dvalid_n_s;
      done_r      <= done_n_s;
      busy_r      <= busy_n_s;
      ce_n_r      <= ce_n_n_s;
    end
  end

  assign oCE_N   = ce_n_r;
  assign oOE_N   = ce_n_r;
  assign oADDR   = addr_r;
  assign oDATA   = word_s;
  assign oDVALID = dvalid_r;
  assign oBUSY   = busy_r;
  assign oDONE   = done_r;

endmodule
